// File: rtl/router_pkg.sv
// Shared encodings for the 2x2 router datapath and its scheduler.
package router_pkg;

   typedef enum logic [1:0] {
      SEL_PASS  = 2'b00,
      SEL_CROSS = 2'b01,
      SEL_BCA   = 2'b10,
      SEL_BCB   = 2'b11
   } sel_e;

   localparam logic [1:0] DST_NONE = 2'b00;
   localparam logic [1:0] DST_X    = 2'b01;
   localparam logic [1:0] DST_Y    = 2'b10;
   localparam logic [1:0] DST_BOTH = 2'b11;

   // Route a lone granted source (A when !is_b, else B) onto every slot in its mask.
   function automatic sel_e sel_single(logic [1:0] dst, logic is_b);
      if (dst == DST_BOTH) begin
         return is_b ? SEL_BCB : SEL_BCA;
      end
      if (is_b) begin
         return (dst == DST_X) ? SEL_CROSS : SEL_PASS;
      end
      return (dst == DST_X) ? SEL_PASS : SEL_CROSS;
   endfunction

endpackage

// File: rtl/router.sv
// Combinational 8-bit 2x2 crossbar: sources a,b steered onto outputs x,y by sel.
module router
   import router_pkg::*;
(
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  sel_e       i_sel,
   output logic [7:0] o_x,
   output logic [7:0] o_y
);

   always_comb begin
      o_x = i_a;
      o_y = i_b;
      unique case (i_sel)
         SEL_PASS: begin
            o_x = i_a;
            o_y = i_b;
         end
         SEL_CROSS: begin
            o_x = i_b;
            o_y = i_a;
         end
         SEL_BCA: begin
            o_x = i_a;
            o_y = i_a;
         end
         SEL_BCB: begin
            o_x = i_b;
            o_y = i_b;
         end
      endcase
   end

endmodule

// File: rtl/router_sched.sv
// Round-robin scheduler around the 2x2 router: grants requesters, fills X/Y output
// slots and counts dropped illegal (dst=00) words.
module router_sched
   import router_pkg::*;
#(
   parameter int unsigned CNT_W     = 8,
   parameter bit          PRIO_INIT = 1'b0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_a_valid,
   input  logic [7:0]       i_a_data,
   input  logic [1:0]       i_a_dst,
   output logic             o_a_ready,
   input  logic             i_b_valid,
   input  logic [7:0]       i_b_data,
   input  logic [1:0]       i_b_dst,
   output logic             o_b_ready,
   output logic             o_x_valid,
   output logic [7:0]       o_x_data,
   input  logic             i_x_ready,
   output logic             o_y_valid,
   output logic [7:0]       o_y_data,
   input  logic             i_y_ready,
   output logic [CNT_W-1:0] o_err_cnt
);

   localparam int unsigned SumW = CNT_W + 1;

   logic             r_prio;
   logic             r_x_valid;
   logic [7:0]       r_x_data;
   logic             r_y_valid;
   logic [7:0]       r_y_data;
   logic [CNT_W-1:0] r_err_cnt;

   logic             w_x_free;
   logic             w_y_free;
   logic             w_a_legal;
   logic             w_b_legal;
   logic             w_a_illegal;
   logic             w_b_illegal;
   logic             w_a_elig;
   logic             w_b_elig;
   logic             w_conflict;
   logic             w_grant_a;
   logic             w_grant_b;
   logic             w_load_x;
   logic             w_load_y;
   sel_e             w_sel;
   logic [7:0]       w_x;
   logic [7:0]       w_y;
   logic [1:0]       w_err_inc;
   logic [SumW-1:0]  w_err_sum;

   assign w_x_free    = !r_x_valid || i_x_ready;
   assign w_y_free    = !r_y_valid || i_y_ready;
   assign w_a_legal   = i_a_valid && (i_a_dst != DST_NONE);
   assign w_b_legal   = i_b_valid && (i_b_dst != DST_NONE);
   assign w_a_illegal = i_a_valid && (i_a_dst == DST_NONE);
   assign w_b_illegal = i_b_valid && (i_b_dst == DST_NONE);

   // A requester is eligible only when every slot in its mask can take a word now.
   assign w_a_elig = w_a_legal && (!i_a_dst[0] || w_x_free) && (!i_a_dst[1] || w_y_free);
   assign w_b_elig = w_b_legal && (!i_b_dst[0] || w_x_free) && (!i_b_dst[1] || w_y_free);
   assign w_conflict = w_a_elig && w_b_elig && ((i_a_dst & i_b_dst) != 2'b00);

   assign w_grant_a = !i_rst && w_a_elig && (!w_conflict || !r_prio);
   assign w_grant_b = !i_rst && w_b_elig && (!w_conflict || r_prio);

   assign o_a_ready = !i_rst && (w_grant_a || w_a_illegal);
   assign o_b_ready = !i_rst && (w_grant_b || w_b_illegal);

   always_comb begin
      w_sel = SEL_PASS;
      if (w_grant_a && w_grant_b) begin
         w_sel = (i_a_dst == DST_X) ? SEL_PASS : SEL_CROSS;
      end else if (w_grant_a) begin
         w_sel = sel_single(i_a_dst, 1'b0);
      end else if (w_grant_b) begin
         w_sel = sel_single(i_b_dst, 1'b1);
      end
   end

   router u_router (
      .i_a   (i_a_data),
      .i_b   (i_b_data),
      .i_sel (w_sel),
      .o_x   (w_x),
      .o_y   (w_y)
   );

   assign w_load_x = (w_grant_a && i_a_dst[0]) || (w_grant_b && i_b_dst[0]);
   assign w_load_y = (w_grant_a && i_a_dst[1]) || (w_grant_b && i_b_dst[1]);

   assign w_err_inc = {1'b0, w_a_illegal} + {1'b0, w_b_illegal};
   assign w_err_sum = {1'b0, r_err_cnt} + SumW'(w_err_inc);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_prio    <= PRIO_INIT;
         r_x_valid <= 1'b0;
         r_x_data  <= 8'h00;
         r_y_valid <= 1'b0;
         r_y_data  <= 8'h00;
         r_err_cnt <= '0;
      end else begin
         // Only a contested grant moves priority, and always to the loser.
         if (w_conflict) begin
            r_prio <= ~r_prio;
         end
         if (w_load_x) begin
            r_x_valid <= 1'b1;
            r_x_data  <= w_x;
         end else if (i_x_ready) begin
            r_x_valid <= 1'b0;
         end
         if (w_load_y) begin
            r_y_valid <= 1'b1;
            r_y_data  <= w_y;
         end else if (i_y_ready) begin
            r_y_valid <= 1'b0;
         end
         r_err_cnt <= w_err_sum[CNT_W] ? '1 : w_err_sum[CNT_W-1:0];
      end
   end

   assign o_x_valid = r_x_valid;
   assign o_x_data  = r_x_data;
   assign o_y_valid = r_y_valid;
   assign o_y_data  = r_y_data;
   assign o_err_cnt = r_err_cnt;

endmodule

// File: tb/tb_router_sched.sv
// Directed bench for router_sched with hand-computed expectations.
module tb_router_sched;

   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             a_valid;
   logic [7:0]       a_data;
   logic [1:0]       a_dst;
   logic             a_ready;
   logic             b_valid;
   logic [7:0]       b_data;
   logic [1:0]       b_dst;
   logic             b_ready;
   logic             x_valid;
   logic [7:0]       x_data;
   logic             x_ready;
   logic             y_valid;
   logic [7:0]       y_data;
   logic             y_ready;
   logic [CNT_W-1:0] err_cnt;

   int n_vec = 0;
   int n_err = 0;

   router_sched #(
      .CNT_W     (CNT_W),
      .PRIO_INIT (1'b0)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_a_valid (a_valid),
      .i_a_data  (a_data),
      .i_a_dst   (a_dst),
      .o_a_ready (a_ready),
      .i_b_valid (b_valid),
      .i_b_data  (b_data),
      .i_b_dst   (b_dst),
      .o_b_ready (b_ready),
      .o_x_valid (x_valid),
      .o_x_data  (x_data),
      .i_x_ready (x_ready),
      .o_y_valid (y_valid),
      .o_y_data  (y_data),
      .i_y_ready (y_ready),
      .o_err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [7:0] ad, input logic [1:0] adst,
                        input logic bv, input logic [7:0] bd, input logic [1:0] bdst);
      a_valid = av;
      a_data  = ad;
      a_dst   = adst;
      b_valid = bv;
      b_data  = bd;
      b_dst   = bdst;
      #1;
   endtask

   logic [7:0] exp_word;

   initial begin
      rst = 1'b1;
      x_ready = 1'b1;
      y_ready = 1'b1;
      drive(1'b1, 8'hEE, 2'b01, 1'b0, 8'h00, 2'b00);
      check("rst_a_ready", a_ready, 0);
      step();
      step();
      check("rst_x_valid", x_valid, 0);
      check("rst_y_valid", y_valid, 0);
      check("rst_x_data", x_data, 0);
      check("rst_y_data", y_data, 0);
      check("rst_err", err_cnt, 0);

      // Disjoint destinations: PASS
      rst = 1'b0;
      drive(1'b1, 8'h11, 2'b01, 1'b1, 8'h22, 2'b10);
      check("pass_a_ready", a_ready, 1);
      check("pass_b_ready", b_ready, 1);
      step();
      check("pass_x_valid", x_valid, 1);
      check("pass_x_data", x_data, 8'h11);
      check("pass_y_valid", y_valid, 1);
      check("pass_y_data", y_data, 8'h22);

      // Swapped destinations: CROSS
      drive(1'b1, 8'h33, 2'b10, 1'b1, 8'h44, 2'b01);
      check("cross_a_ready", a_ready, 1);
      check("cross_b_ready", b_ready, 1);
      step();
      check("cross_x_data", x_data, 8'h44);
      check("cross_y_data", y_data, 8'h33);

      // Both to X: round-robin A,B,A,B with drain+load each cycle
      drive(1'b1, 8'hA1, 2'b01, 1'b1, 8'hB2, 2'b01);
      for (int i = 0; i < 4; i++) begin
         check("rr_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
         check("rr_b_ready", b_ready, (i % 2 == 0) ? 0 : 1);
         step();
         exp_word = (i % 2 == 0) ? 8'hA1 : 8'hB2;
         check("rr_x_valid", x_valid, 1);
         check("rr_x_data", x_data, exp_word);
      end

      // Occupy Y with a stalled word, then broadcast from A
      y_ready = 1'b0;
      drive(1'b0, 8'h00, 2'b00, 1'b1, 8'h77, 2'b10);
      step();
      check("bc_pre_y_data", y_data, 8'h77);
      check("bc_pre_x_valid", x_valid, 0);
      drive(1'b1, 8'h5A, 2'b11, 1'b0, 8'h00, 2'b00);
      check("bc_blocked_ready", a_ready, 0);
      step();
      check("bc_hold_y_valid", y_valid, 1);
      check("bc_hold_y_data", y_data, 8'h77);
      check("bc_hold_x_valid", x_valid, 0);
      y_ready = 1'b1;
      #1;
      check("bc_ready", a_ready, 1);
      step();
      check("bc_x_valid", x_valid, 1);
      check("bc_x_data", x_data, 8'h5A);
      check("bc_y_valid", y_valid, 1);
      check("bc_y_data", y_data, 8'h5A);

      // Drain without load keeps data
      drive(1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00);
      step();
      check("drain_x_valid", x_valid, 0);
      check("drain_x_data", x_data, 8'h5A);

      // Both illegal in one cycle counts two
      drive(1'b1, 8'h01, 2'b00, 1'b1, 8'h02, 2'b00);
      check("ill2_a_ready", a_ready, 1);
      check("ill2_b_ready", b_ready, 1);
      step();
      check("ill2_err", err_cnt, 2);
      check("ill2_x_valid", x_valid, 0);

      // A illegal for 300 cycles: saturate at 255
      drive(1'b1, 8'h03, 2'b00, 1'b0, 8'h00, 2'b00);
      for (int i = 0; i < 300; i++) begin
         check("sat_a_ready", a_ready, 1);
         step();
         if (i == 9) check("sat_err_mid", err_cnt, 12);
      end
      check("sat_err", err_cnt, 255);

      // Conflict moves prio to B, then hold a word in X
      drive(1'b1, 8'hC1, 2'b01, 1'b1, 8'hC2, 2'b01);
      check("pre_rst_a_ready", a_ready, 1);
      step();
      check("pre_rst_x_data", x_data, 8'hC1);
      x_ready = 1'b0;
      drive(1'b0, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00);
      step();
      check("pre_rst_x_valid", x_valid, 1);

      // Reset mid-stream
      rst = 1'b1;
      x_ready = 1'b1;
      drive(1'b1, 8'hD1, 2'b01, 1'b0, 8'h00, 2'b00);
      check("rst2_a_ready", a_ready, 0);
      step();
      check("rst2_x_valid", x_valid, 0);
      check("rst2_x_data", x_data, 0);
      check("rst2_err", err_cnt, 0);
      rst = 1'b0;
      drive(1'b1, 8'hE1, 2'b01, 1'b1, 8'hE2, 2'b01);
      check("rst2_prio_a", a_ready, 1);
      check("rst2_prio_b", b_ready, 0);
      step();
      check("rst2_x_data_after", x_data, 8'hE1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
